// File: rtl/dma_pkg.sv
// Shared DMA definitions: read-engine state encoding, address step default and
// the bus read-response bundle used by both source and destination engines.
package dma_pkg;

   localparam int ADDR_STEP_DEF = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      REQ   = 3'd2,
      WAIT  = 3'd3,
      PUSH  = 3'd4,
      DRAIN = 3'd5,
      FIN   = 3'd6
   } rd_state_t;

   typedef struct packed {
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
   } bus_rsp_t;

endpackage

// File: rtl/dma_src_reader.sv
// Source-side DMA read engine: one outstanding word read at a time, issued only
// when the downstream FIFO has room, each returned word pushed into the FIFO.
module dma_src_reader
   import dma_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int LEN_W     = 16,
   parameter int ADDR_STEP = ADDR_STEP_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [LEN_W-1:0]  words_done,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_err,
   output logic              fifo_clear,
   output logic              fifo_wr,
   output logic [31:0]       fifo_wdata,
   input  logic              fifo_full
);

   rd_state_t         state, state_nxt;
   bus_rsp_t          rsp;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  cnt_inc;
   logic              busy_d, done_d, clr_d, wr_d;

   assign rsp      = '{rvalid: bus_rvalid, err: bus_err, rdata: bus_rdata};
   assign cnt_inc  = words_done + LEN_W'(1);
   assign bus_req  = (state == REQ) && !fifo_full;
   assign bus_addr = addr;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = CLR;
         CLR:   state_nxt = (abort || len_q == '0) ? FIN : REQ;
         REQ: begin
            if (abort)                 state_nxt = FIN;
            else if (bus_req && bus_gnt) state_nxt = WAIT;
         end
         WAIT: begin
            // Abort coinciding with the response retires the read directly.
            if (rsp.rvalid && (rsp.err || abort)) state_nxt = FIN;
            else if (rsp.rvalid)                  state_nxt = PUSH;
            else if (abort)                       state_nxt = DRAIN;
         end
         PUSH:  state_nxt = (abort || cnt_inc == len_q) ? FIN : REQ;
         DRAIN: if (rsp.rvalid) state_nxt = FIN;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they register glitch-free.
   always_comb begin
      busy_d = (state_nxt != IDLE);
      done_d = (state_nxt == FIN);
      clr_d  = (state_nxt == CLR);
      wr_d   = (state_nxt == PUSH);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         fifo_clear <= 1'b0;
         fifo_wr    <= 1'b0;
      end else begin
         busy       <= busy_d;
         done       <= done_d;
         fifo_clear <= clr_d;
         fifo_wr    <= wr_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         addr       <= '0;
         len_q      <= '0;
         words_done <= '0;
         error      <= 1'b0;
         fifo_wdata <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               addr       <= src_addr;
               len_q      <= len;
               words_done <= '0;
               error      <= 1'b0;
            end
            WAIT: if (rsp.rvalid && !abort) begin
               if (rsp.err) error      <= 1'b1;
               else         fifo_wdata <= rsp.rdata;
            end
            PUSH: begin
               words_done <= cnt_inc;
               addr       <= addr + ADDR_W'(ADDR_STEP);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_src_reader.sv
// Bench for dma_src_reader: bus/FIFO responder, scoreboard queues filled by the
// directed stimulus and drained by a monitor on pushes, grants and done pulses.
module tb_dma_src_reader;
   import dma_pkg::*;

   typedef struct packed {
      logic        err;
      logic [15:0] wd;
   } dexp_t;

   logic        clk = 1'b0;
   logic        rstn, start, abort, busy, done, error, bus_req, bus_gnt;
   logic        bus_rvalid, bus_err, fifo_clear, fifo_wr, fifo_full;
   logic [31:0] src_addr, bus_addr, bus_rdata, fifo_wdata;
   logic [15:0] len, words_done;

   int checks = 0, errors = 0;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   dexp_t       exp_done_q[$];

   // main-owned knobs
   int lat = 1, err_at = -1, pop_req = 0, clr_base = 0;
   bit fifo_lim = 0;
   // model/monitor-owned state
   int gnt_cnt = 0, rsp_cnt = 0, fifo_cnt = 0, pops_done = 0, clr_total = 0, pcnt = 0;
   bit pend = 0;
   logic [31:0] raddr = '0;

   always #5 clk = ~clk;

   dma_src_reader dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .src_addr(src_addr),
      .len(len), .busy(busy), .done(done), .error(error), .words_done(words_done),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err), .fifo_clear(fifo_clear), .fifo_wr(fifo_wr),
      .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Bus and FIFO responder
   initial begin
      bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0; fifo_full = 1'b0;
      forever begin
         @(negedge clk);
         bus_rvalid = 1'b0; bus_err = 1'b0;
         if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
               bus_rvalid = 1'b1;
               bus_rdata  = raddr ^ 32'hCAFE_0000;
               bus_err    = (rsp_cnt == err_at);
               rsp_cnt++;
               pend = 0;
            end
         end
         if (!fifo_lim) fifo_cnt = 0;
         else begin
            if (fifo_wr) begin
               chk("fifo_no_overflow", fifo_cnt < 8, 1);
               fifo_cnt++;
            end
            if (pops_done < pop_req && fifo_cnt > 0) begin
               fifo_cnt--;
               pops_done++;
            end
         end
         fifo_full = fifo_lim && fifo_cnt >= 8;
         #1;
         if (bus_req && bus_gnt) begin
            gnt_cnt++;
            chk("clear_before_req", clr_total > clr_base, 1);
            chk("addr_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) chk("bus_addr", bus_addr, exp_addr_q.pop_front());
            pend  = 1;
            pcnt  = lat;
            raddr = bus_addr;
         end
      end
   end

   // Scoreboard monitor
   initial begin
      dexp_t d;
      forever begin
         @(negedge clk);
         if (fifo_clear) clr_total++;
         if (fifo_wr) begin
            chk("push_expected", exp_data_q.size() != 0, 1);
            if (exp_data_q.size() != 0) chk("fifo_wdata", fifo_wdata, exp_data_q.pop_front());
         end
         if (done) begin
            chk("done_expected", exp_done_q.size() != 0, 1);
            chk("busy_with_done", busy, 1);
            if (exp_done_q.size() != 0) begin
               d = exp_done_q.pop_front();
               chk("done_error", error, d.err);
               chk("done_words", words_done, d.wd);
            end
         end
      end
   end

   task automatic kick(input logic [31:0] a, input logic [15:0] n);
      @(negedge clk);
      clr_base = clr_total;
      src_addr = a; len = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("done_in_time", done, 1);
      @(negedge clk);
      chk("busy_dropped", busy, 0);
   endtask

   task automatic wait_gnts(input int target);
      int k = 0;
      while (gnt_cnt < target && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("grant_in_time", gnt_cnt >= target, 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
      chk({tag, "_words"}, words_done, 0);
      chk({tag, "_req"}, bus_req, 0);
      chk({tag, "_addr"}, bus_addr, 0);
      chk({tag, "_clear"}, fifo_clear, 0);
      chk({tag, "_wr"}, fifo_wr, 0);
      chk({tag, "_wdata"}, fifo_wdata, 0);
   endtask

   initial begin
      int g0;
      rstn = 1'b0; start = 1'b0; abort = 1'b0; src_addr = '0; len = '0; bus_gnt = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outs("reset");
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Basic 3-word transfer
      for (int i = 0; i < 3; i++) begin
         exp_addr_q.push_back(32'h1000 + 4 * i);
         exp_data_q.push_back(32'hCAFE_1000 + 4 * i);
      end
      exp_done_q.push_back('{1'b0, 16'd3});
      kick(32'h1000, 16'd3);
      wait_done(100);
      chk("basic_words", words_done, 3);
      chk("basic_one_clear", clr_total - clr_base, 1);

      // Backpressure: FIFO of depth 8, no reads until stalled
      fifo_lim = 1;
      for (int i = 0; i < 10; i++) begin
         exp_addr_q.push_back(32'h2000 + 4 * i);
         exp_data_q.push_back(32'hCAFE_2000 + 4 * i);
      end
      exp_done_q.push_back('{1'b0, 16'd10});
      g0 = gnt_cnt;
      kick(32'h2000, 16'd10);
      for (int k = 0; k < 400 && !fifo_full; k++) @(negedge clk);
      chk("bp_full", fifo_full, 1);
      repeat (6) @(negedge clk);
      chk("bp_req_low", bus_req, 0);
      chk("bp_words", words_done, 8);
      chk("bp_grants", gnt_cnt - g0, 8);
      chk("bp_busy", busy, 1);
      pop_req = pop_req + 2;
      wait_done(200);
      fifo_lim = 0;

      // Bus error on the second response
      err_at = rsp_cnt + 1;
      exp_addr_q.push_back(32'h3000);
      exp_addr_q.push_back(32'h3004);
      exp_data_q.push_back(32'hCAFE_3000);
      exp_done_q.push_back('{1'b1, 16'd1});
      kick(32'h3000, 16'd4);
      wait_done(100);
      repeat (3) @(negedge clk);
      chk("err_held", error, 1);
      err_at = -1;

      // Zero length; also shows error cleared by the new start
      exp_done_q.push_back('{1'b0, 16'd0});
      g0 = gnt_cnt;
      kick(32'h5000, 16'd0);
      chk("zero_clear", fifo_clear, 1);
      chk("zero_err_cleared", error, 0);
      chk("zero_no_done_yet", done, 0);
      @(negedge clk);
      chk("zero_done_t2", done, 1);
      @(negedge clk);
      chk("zero_busy_off", busy, 0);
      chk("zero_no_grant", gnt_cnt - g0, 0);

      // Abort in WAIT after the second grant; late response is drained
      lat = 3;
      exp_addr_q.push_back(32'h4000);
      exp_addr_q.push_back(32'h4004);
      exp_data_q.push_back(32'hCAFE_4000);
      exp_done_q.push_back('{1'b0, 16'd1});
      g0 = gnt_cnt;
      kick(32'h4000, 16'd5);
      wait_gnts(g0 + 2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(50);
      chk("abort_words", words_done, 1);
      chk("abort_grants", gnt_cnt - g0, 2);
      lat = 1;

      // start while busy is ignored
      exp_addr_q.push_back(32'h6000);
      exp_addr_q.push_back(32'h6004);
      exp_data_q.push_back(32'hCAFE_6000);
      exp_data_q.push_back(32'hCAFE_6004);
      exp_done_q.push_back('{1'b0, 16'd2});
      kick(32'h6000, 16'd2);
      @(negedge clk);
      src_addr = 32'h9000; len = 16'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(100);
      chk("busy_start_one_clear", clr_total - clr_base, 1);

      // Address wrap-around
      exp_addr_q.push_back(32'hFFFF_FFFC);
      exp_addr_q.push_back(32'h0000_0000);
      exp_data_q.push_back(32'h3501_FFFC);
      exp_data_q.push_back(32'hCAFE_0000);
      exp_done_q.push_back('{1'b0, 16'd2});
      kick(32'hFFFF_FFFC, 16'd2);
      wait_done(100);
      chk("wrap_words", words_done, 2);

      // Reset while waiting for a response
      lat = 3;
      exp_addr_q.push_back(32'h7000);
      g0 = gnt_cnt;
      kick(32'h7000, 16'd3);
      wait_gnts(g0 + 1);
      chk("midwait_busy", busy, 1);
      rstn = 1'b0;
      #1;
      chk_reset_outs("midrst");
      repeat (5) @(negedge clk);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_idle", busy, 0);
      lat = 1;

      chk("addr_q_empty", exp_addr_q.size(), 0);
      chk("data_q_empty", exp_data_q.size(), 0);
      chk("done_q_empty", exp_done_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
